// File: rtl/u712_reg_arb.sv
// rtl/u712_reg_arb.sv - CPU/PCI arbiter and sequencer for the Agnus register cycle state machine
//
// Shares the single chipset register path between the CPU (TS-qualified register-space access)
// and the PCI bridge (level request). Issues one start strobe per cycle and routes REG_TACK back
// to the owner. It also synchronizes _DBR and enforces HOLDOFF spacing between cycles.
// All logic runs on the falling edge of CLK80, like the register state machine it feeds.
//
// Optional feature macro: REG_WDT_EN enables a grant-to-TACK watchdog (WDT_CLKS).
//
// Ports:
//   CLK80, RESETn                     clock (negedge) and synchronous active-low reset
//   CPU_TSn/REGSPn/RnW/UDS/LDS        CPU request and attributes
//   PCI_REQ/RnW/UDS/LDS               PCI bridge level request and attributes
//   DBRn                              asynchronous Agnus _DBR
//   REG_TACK, REG_CYCLE               handshake from the register state machine
//   SM_TSn/REGSPn/RnW/UDS/LDS         start strobe and attributes to the state machine
//   DBR_SYNC                          synchronized, inverted _DBR
//   CPU_ACK, PCI_ACK                  one-clock acks to the owner
//   OWNER, BUSY, WDT_ERR              status outputs
module u712_reg_arb #(
  parameter int HOLDOFF_CLKS = 2
`ifdef REG_WDT_EN
  , parameter int WDT_CLKS = 4095
`endif
) (
  input  logic CLK80,
  input  logic RESETn,
  input  logic CPU_TSn,
  input  logic CPU_REGSPn,
  input  logic CPU_RnW,
  input  logic CPU_UDS,
  input  logic CPU_LDS,
  input  logic PCI_REQ,
  input  logic PCI_RnW,
  input  logic PCI_UDS,
  input  logic PCI_LDS,
  input  logic DBRn,
  input  logic REG_TACK,
  input  logic REG_CYCLE,
  output logic SM_TSn,
  output logic SM_REGSPn,
  output logic SM_RnW,
  output logic SM_UDS,
  output logic SM_LDS,
  output logic DBR_SYNC,
  output logic CPU_ACK,
  output logic PCI_ACK,
  output logic OWNER,
  output logic BUSY,
  output logic WDT_ERR
);

  typedef enum logic [1:0] {IDLE, GRANT, WAIT_TACK, HOLDOFF} state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLDOFF_CLKS - 1);

  state_t     state;
  logic       cpu_pend, cpu_rnw_q, cpu_uds_q, cpu_lds_q;
  logic       last_pci;
  logic       dbr_meta;
  logic [3:0] hcnt;

  logic cpu_ts_hit, cpu_req, pick_pci, hold_done;
  logic cpu_rnw, cpu_uds, cpu_lds;

  assign cpu_ts_hit = !CPU_TSn && !CPU_REGSPn;
  // A TS seen in IDLE is granted on the same edge it is captured, so the raw strobe counts
  // as a request and supplies the attributes until the captured copy is valid.
  assign cpu_req  = cpu_pend || cpu_ts_hit;
  assign cpu_rnw  = cpu_pend ? cpu_rnw_q : CPU_RnW;
  assign cpu_uds  = cpu_pend ? cpu_uds_q : CPU_UDS;
  assign cpu_lds  = cpu_pend ? cpu_lds_q : CPU_LDS;
  // On a tie the requester not served last wins; otherwise whoever is asking.
  assign pick_pci = PCI_REQ && (!cpu_req || !last_pci);
  assign hold_done = (hcnt >= HOLD_LAST) && !REG_CYCLE;

`ifdef REG_WDT_EN
  logic [11:0] wdt;
`else
  assign WDT_ERR = 1'b0;
`endif

  always_ff @(negedge CLK80) begin
    if (!RESETn) begin
      state     <= IDLE;
      SM_TSn    <= 1'b1;
      SM_REGSPn <= 1'b1;
      SM_RnW    <= 1'b1;
      SM_UDS    <= 1'b0;
      SM_LDS    <= 1'b0;
      DBR_SYNC  <= 1'b0;
      dbr_meta  <= 1'b0;
      CPU_ACK   <= 1'b0;
      PCI_ACK   <= 1'b0;
      OWNER     <= 1'b0;
      BUSY      <= 1'b0;
      cpu_pend  <= 1'b0;
      cpu_rnw_q <= 1'b1;
      cpu_uds_q <= 1'b0;
      cpu_lds_q <= 1'b0;
      last_pci  <= 1'b1;
      hcnt      <= 4'd0;
`ifdef REG_WDT_EN
      WDT_ERR   <= 1'b0;
      wdt       <= 12'd0;
`endif
    end else begin
      SM_TSn    <= 1'b1;
      SM_REGSPn <= 1'b1;
      CPU_ACK   <= 1'b0;
      PCI_ACK   <= 1'b0;
`ifdef REG_WDT_EN
      WDT_ERR   <= 1'b0;
`endif
      dbr_meta  <= !DBRn;
      DBR_SYNC  <= dbr_meta;

      // The CPU never pipelines register cycles, so a second TS while pending is dropped.
      if (cpu_ts_hit && !cpu_pend) begin
        cpu_pend  <= 1'b1;
        cpu_rnw_q <= CPU_RnW;
        cpu_uds_q <= CPU_UDS;
        cpu_lds_q <= CPU_LDS;
      end

      case (state)
        IDLE: begin
          if (cpu_req || PCI_REQ) begin
            OWNER  <= pick_pci;
            BUSY   <= 1'b1;
            SM_RnW <= pick_pci ? PCI_RnW : cpu_rnw;
            SM_UDS <= pick_pci ? PCI_UDS : cpu_uds;
            SM_LDS <= pick_pci ? PCI_LDS : cpu_lds;
`ifdef REG_WDT_EN
            wdt    <= 12'd0;
`endif
            state  <= GRANT;
          end
        end
        GRANT: begin
          SM_TSn    <= 1'b0;
          SM_REGSPn <= 1'b0;
          state     <= WAIT_TACK;
        end
        WAIT_TACK: begin
`ifdef REG_WDT_EN
          wdt <= wdt + 12'd1;
          if (REG_TACK || (wdt == 12'(WDT_CLKS - 1))) begin
            WDT_ERR <= !REG_TACK;
`else
          if (REG_TACK) begin
`endif
            if (OWNER) PCI_ACK <= 1'b1;
            else begin
              CPU_ACK  <= 1'b1;
              cpu_pend <= 1'b0;
            end
            last_pci <= OWNER;
            hcnt     <= 4'd0;
            state    <= HOLDOFF;
          end
        end
        HOLDOFF: begin
          if (hold_done) begin
            SM_RnW <= 1'b1;
            SM_UDS <= 1'b0;
            SM_LDS <= 1'b0;
            BUSY   <= 1'b0;
            state  <= IDLE;
          end else if (hcnt != 4'hF) begin
            hcnt <= hcnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_u712_reg_arb.sv
// tb/tb_u712_reg_arb.sv - directed scoreboard bench for u712_reg_arb
module tb_u712_reg_arb;

  logic CLK80 = 1'b1;
  logic RESETn = 1'b0;
  logic CPU_TSn = 1'b1, CPU_REGSPn = 1'b1, CPU_RnW = 1'b1, CPU_UDS = 1'b0, CPU_LDS = 1'b0;
  logic PCI_REQ = 1'b0, PCI_RnW = 1'b1, PCI_UDS = 1'b0, PCI_LDS = 1'b0;
  logic DBRn = 1'b1, REG_TACK = 1'b0, REG_CYCLE = 1'b0;
  logic SM_TSn, SM_REGSPn, SM_RnW, SM_UDS, SM_LDS, DBR_SYNC;
  logic CPU_ACK, PCI_ACK, OWNER, BUSY, WDT_ERR;

  int checks = 0;
  int errors = 0;
  int n;

  // grant record {owner, rnw, uds, lds}; ack record = owner (0 CPU, 1 PCI)
  logic [3:0] grant_q[$];
  logic       ack_q[$];
  logic [3:0] g;
  logic       e;

  always #6 CLK80 = ~CLK80;

  u712_reg_arb dut (
    .CLK80(CLK80), .RESETn(RESETn),
    .CPU_TSn(CPU_TSn), .CPU_REGSPn(CPU_REGSPn), .CPU_RnW(CPU_RnW), .CPU_UDS(CPU_UDS), .CPU_LDS(CPU_LDS),
    .PCI_REQ(PCI_REQ), .PCI_RnW(PCI_RnW), .PCI_UDS(PCI_UDS), .PCI_LDS(PCI_LDS),
    .DBRn(DBRn), .REG_TACK(REG_TACK), .REG_CYCLE(REG_CYCLE),
    .SM_TSn(SM_TSn), .SM_REGSPn(SM_REGSPn), .SM_RnW(SM_RnW), .SM_UDS(SM_UDS), .SM_LDS(SM_LDS),
    .DBR_SYNC(DBR_SYNC), .CPU_ACK(CPU_ACK), .PCI_ACK(PCI_ACK), .OWNER(OWNER), .BUSY(BUSY),
    .WDT_ERR(WDT_ERR)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Outputs change on negedge; everything here samples on posedge.
  always @(posedge CLK80) begin
    if (SM_TSn === 1'b0) begin
      if (grant_q.size() == 0) check("grant_unexpected", 8'd1, 8'd0);
      else begin
        g = grant_q.pop_front();
        check("grant_attr", {2'b00, BUSY, SM_REGSPn, OWNER, SM_RnW, SM_UDS, SM_LDS}, {4'b0010, g});
      end
    end
    if (CPU_ACK === 1'b1 || PCI_ACK === 1'b1) begin
      if (ack_q.size() == 0) check("ack_unexpected", {6'd0, CPU_ACK, PCI_ACK}, 8'd0);
      else begin
        e = ack_q.pop_front();
        check("ack_route", {6'd0, CPU_ACK, PCI_ACK}, e ? 8'd1 : 8'd2);
      end
    end
  end

  task automatic do_reset();
    RESETn = 1'b0;
    repeat (2) @(posedge CLK80);
    RESETn = 1'b1;
    @(posedge CLK80);
  endtask

  task automatic cpu_ts(input logic rnw, input logic uds, input logic lds);
    CPU_TSn = 1'b0; CPU_REGSPn = 1'b0;
    CPU_RnW = rnw; CPU_UDS = uds; CPU_LDS = lds;
    @(posedge CLK80);
    CPU_TSn = 1'b1; CPU_REGSPn = 1'b1;
  endtask

  task automatic wait_grant(output int cnt);
    cnt = 0;
    do begin
      @(posedge CLK80);
      cnt++;
    end while (SM_TSn !== 1'b0 && cnt < 20);
    check("grant_seen", {7'd0, SM_TSn}, 8'd0);
  endtask

  // Returns on the posedge where the routed ack is visible.
  task automatic serve(input int dly, output int cnt);
    wait_grant(cnt);
    repeat (dly) @(posedge CLK80);
    REG_TACK = 1'b1;
    @(posedge CLK80);
    REG_TACK = 1'b0;
  endtask

  initial begin
    // reset values
    repeat (3) @(posedge CLK80);
    check("rst_sm", {3'd0, SM_TSn, SM_REGSPn, SM_RnW, SM_UDS, SM_LDS}, 8'b0001_1100);
    check("rst_misc", {2'd0, DBR_SYNC, CPU_ACK, PCI_ACK, OWNER, BUSY, WDT_ERR}, 8'd0);
    RESETn = 1'b1;
    repeat (2) @(posedge CLK80);

    // CPU read: strobe two clocks after the request, ack routed to CPU only
    grant_q.push_back(4'b0111); ack_q.push_back(1'b0);
    cpu_ts(1'b1, 1'b1, 1'b1);
    check("cpu_ts_not_yet", {7'd0, SM_TSn}, 8'd1);
    serve(1, n);
    check("cpu_latency", 8'(n), 8'd1);
    check("cpu_ack_only", {6'd0, CPU_ACK, PCI_ACK}, 8'b10);
    @(posedge CLK80);
    check("holdoff_busy", {7'd0, BUSY}, 8'd1);
    @(posedge CLK80);
    check("holdoff_done", {7'd0, BUSY}, 8'd0);

    // simultaneous CPU and PCI after reset: CPU first, PCI after HOLDOFF
    do_reset();
    grant_q.push_back(4'b0010); grant_q.push_back(4'b1101);
    ack_q.push_back(1'b0); ack_q.push_back(1'b1);
    PCI_RnW = 1'b1; PCI_UDS = 1'b0; PCI_LDS = 1'b1; PCI_REQ = 1'b1;
    cpu_ts(1'b0, 1'b1, 1'b0);
    serve(1, n);
    check("cpu_first", 8'(n), 8'd1);
    @(posedge CLK80);
    @(posedge CLK80);
    check("tie_gap_idle", {7'd0, BUSY}, 8'd0);
    serve(1, n);
    check("pci_after_holdoff", 8'(n), 8'd2);
    PCI_REQ = 1'b0;
    repeat (3) @(posedge CLK80);

    // PCI held, CPU re-requests each cycle: owners must alternate
    grant_q.push_back(4'b0101); grant_q.push_back(4'b1011);
    grant_q.push_back(4'b0011); grant_q.push_back(4'b1011);
    ack_q.push_back(1'b0); ack_q.push_back(1'b1); ack_q.push_back(1'b0); ack_q.push_back(1'b1);
    PCI_RnW = 1'b0; PCI_UDS = 1'b1; PCI_LDS = 1'b1; PCI_REQ = 1'b1;
    cpu_ts(1'b1, 1'b0, 1'b1);
    CPU_RnW = 1'b0; CPU_LDS = 1'b0;
    serve(1, n);
    cpu_ts(1'b0, 1'b1, 1'b1);
    CPU_RnW = 1'b1; CPU_UDS = 1'b0; CPU_LDS = 1'b0;
    serve(1, n);
    check("alt_pci_gap", 8'(n), 8'd3);
    serve(1, n);
    serve(1, n);
    PCI_REQ = 1'b0;
    repeat (3) @(posedge CLK80);

    // stray TACK in IDLE is ignored
    REG_TACK = 1'b1;
    @(posedge CLK80);
    REG_TACK = 1'b0;
    @(posedge CLK80);
    check("stray_tack", {5'd0, CPU_ACK, PCI_ACK, BUSY}, 8'd0);

    // REG_CYCLE stretches HOLDOFF and attributes stay held
    grant_q.push_back(4'b0001); ack_q.push_back(1'b0);
    cpu_ts(1'b0, 1'b0, 1'b1);
    REG_CYCLE = 1'b1;
    serve(1, n);
    @(posedge CLK80);
    check("cyc_busy_a", {7'd0, BUSY}, 8'd1);
    @(posedge CLK80);
    check("cyc_hold_attr", {4'd0, BUSY, SM_RnW, SM_UDS, SM_LDS}, 8'b1001);
    REG_CYCLE = 1'b0;
    @(posedge CLK80);
    check("holdoff_release", {4'd0, BUSY, SM_RnW, SM_UDS, SM_LDS}, 8'b0100);

    // DBR synchronizer: two negedge flops, inverted
    #3 DBRn = 1'b0;
    @(posedge CLK80);
    check("dbr_lag", {7'd0, DBR_SYNC}, 8'd0);
    @(posedge CLK80);
    check("dbr_assert", {7'd0, DBR_SYNC}, 8'd1);
    #3 DBRn = 1'b1;
    @(posedge CLK80);
    check("dbr_hold", {7'd0, DBR_SYNC}, 8'd1);
    @(posedge CLK80);
    check("dbr_negate", {7'd0, DBR_SYNC}, 8'd0);

    // reset during WAIT_TACK: cycle abandoned, late TACK yields no ack
    grant_q.push_back(4'b0111);
    cpu_ts(1'b1, 1'b1, 1'b1);
    wait_grant(n);
    RESETn = 1'b0;
    @(posedge CLK80);
    check("reset_mid", {4'd0, BUSY, SM_TSn, SM_REGSPn, OWNER}, 8'b0110);
    RESETn = 1'b1;
    REG_TACK = 1'b1;
    @(posedge CLK80);
    REG_TACK = 1'b0;
    @(posedge CLK80);
    check("tack_after_reset", {5'd0, CPU_ACK, PCI_ACK, BUSY}, 8'd0);
    repeat (4) @(posedge CLK80);

    check("grant_q_empty", 8'(grant_q.size()), 8'd0);
    check("ack_q_empty", 8'(ack_q.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
